// File: rtl/four_input_debouncer.sv
// Four independent switch debouncers with two-flop synchronizers,
// registered level outputs, edge pulses and a busy flag.
module four_input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  output logic [3:0] sw_out,
  output logic [3:0] sw_rise,
  output logic [3:0] sw_fall,
  output logic       busy
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_COUNT  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    out_q, out_d;
  logic [3:0]    rise_q, rise_d;
  logic [3:0]    fall_q, fall_d;
  logic          busy_q, busy_d;
  logic [0:0]    state_q [4];
  logic [0:0]    state_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  always_comb begin
    out_d  = out_q;
    rise_d = 4'b0000;
    fall_d = 4'b0000;
    busy_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != out_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i] = '0;
          end
        end
        ST_COUNT: begin
          if (sync2_q[i] == out_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            // Level held long enough: accept and pulse
            out_d[i]   = sync2_q[i];
            rise_d[i]  = sync2_q[i];
            fall_d[i]  = ~sync2_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
      busy_d = busy_d | (state_d[i] == ST_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      out_q   <= 4'b0000;
      rise_q  <= 4'b0000;
      fall_q  <= 4'b0000;
      busy_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw_out  = out_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_four_input_debouncer.sv
// Scoreboard bench for four_input_debouncer with STABLE_CYCLES=4:
// a run-length reference model plus directed latency/pulse-count checks.
module tb_four_input_debouncer;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       busy;

  int checks = 0;
  int errs   = 0;

  logic [12:0] exp_q [$];

  logic [3:0] m1, m2, mout, mrise, mfall;
  int         mrun [4];
  int         nrise [4];
  int         nfall [4];

  four_input_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: accept a flip once the synchronized level has differed
  // from the output on SC consecutive edges.
  task automatic model_edge(input logic r, input logic [3:0] x);
    logic mb;
    mb = 1'b0;
    mrise = '0;
    mfall = '0;
    if (r) begin
      m1 = '0; m2 = '0; mout = '0;
      for (int i = 0; i < 4; i++) mrun[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m2[i] != mout[i]) begin
          mrun[i]++;
          if (mrun[i] >= SC) begin
            mout[i]  = m2[i];
            mrise[i] = m2[i];
            mfall[i] = ~m2[i];
            mrun[i]  = 0;
          end
        end else begin
          mrun[i] = 0;
        end
        if (mrun[i] > 0) mb = 1'b1;
      end
      m2 = m1;
      m1 = x;
    end
    exp_q.push_back({mout, mrise, mfall, mb});
  endtask

  task automatic step(input logic r, input logic [3:0] x);
    logic [12:0] e;
    @(negedge clk);
    rst   = r;
    sw_in = x;
    @(posedge clk);
    model_edge(r, x);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("cycle", int'({sw_out, sw_rise, sw_fall, busy}), int'(e));
    end
    chk("rise_fall_excl", int'(sw_rise & sw_fall), 0);
    for (int i = 0; i < 4; i++) begin
      if (sw_rise[i]) nrise[i]++;
      if (sw_fall[i]) nfall[i]++;
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 4; i++) begin
      nrise[i] = 0;
      nfall[i] = 0;
    end
  endtask

  initial begin
    int idx;
    rst   = 1'b1;
    sw_in = 4'b0000;
    m1 = '0; m2 = '0; mout = '0;
    for (int i = 0; i < 4; i++) mrun[i] = 0;
    clr_cnt();

    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000);
    chk("rst_out", int'(sw_out), 0);
    chk("rst_busy", int'(busy), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0000);

    // Clean edge on channel 0
    clr_cnt();
    idx = -1;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 4'b0001);
      if (k == 2) chk("busy_e2", int'(busy), 1);
      if (k == 5) chk("busy_e5", int'(busy), 0);
      if (idx < 0 && sw_rise[0]) idx = k;
    end
    chk("lat_ch0", idx, SC + 1);
    chk("rise_ch0", nrise[0], 1);
    chk("out_ch0", int'(sw_out), 1);

    clr_cnt();
    for (int k = 0; k < 9; k++) step(1'b0, 4'b0000);
    chk("fall_ch0", nfall[0], 1);

    // Glitch just short of acceptance
    clr_cnt();
    for (int k = 0; k < SC - 1; k++) step(1'b0, 4'b0100);
    for (int k = 0; k < 9; k++) step(1'b0, 4'b0000);
    chk("glitch_rise", nrise[2], 0);
    chk("glitch_out", int'(sw_out), 0);

    // Exactly long enough
    clr_cnt();
    for (int k = 0; k < SC; k++) step(1'b0, 4'b0100);
    for (int k = 0; k < 10; k++) step(1'b0, 4'b0000);
    chk("bound_rise", nrise[2], 1);
    chk("bound_fall", nfall[2], 1);

    // Bounce on channel 1
    clr_cnt();
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    idx = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0010);
      if (idx < 0 && sw_rise[1]) idx = k;
    end
    chk("bounce_rise", nrise[1], 1);
    chk("bounce_lat", idx, SC + 1);
    for (int k = 0; k < 9; k++) step(1'b0, 4'b0000);

    // All four together
    clr_cnt();
    idx = -1;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 4'b1111);
      if (idx < 0 && sw_out == 4'b1111) begin
        idx = k;
        chk("sim_rise", int'(sw_rise), 15);
      end
    end
    chk("sim_lat", idx, SC + 1);
    for (int k = 0; k < 9; k++) step(1'b0, 4'b0000);
    chk("sim_fall", nfall[0] + nfall[1] + nfall[2] + nfall[3], 4);

    // Reset while channel 3 is mid-count
    clr_cnt();
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1000);
    chk("mid_busy", int'(busy), 1);
    step(1'b1, 4'b1000);
    chk("mid_rst_out", int'({sw_out, sw_rise, sw_fall, busy}), 0);
    idx = -1;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 4'b1000);
      if (idx < 0 && sw_rise[3]) idx = k;
    end
    chk("mid_lat", idx, SC + 1);
    chk("mid_rise", nrise[3], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/four_input_debouncer.md
FOUR_INPUT_DEBOUNCER -- requirements
Module: four_input_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 100000, is the number of consecutive cycles a synchronized input SHALL hold a new level before acceptance; the legal range is 2 to 2^20.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 sw_in  input  4  SHALL carry raw, asynchronous, bouncing switch levels; bit i is channel i.
REQ-005 sw_out  output  4  SHALL carry the debounced levels; bits 0..3 drive inputs a, b, c, d of the downstream four-input NOR stage.
REQ-006 sw_rise  output  4  SHALL carry a one-cycle pulse per channel when sw_out[i] goes 0->1.
REQ-007 sw_fall  output  4  SHALL carry a one-cycle pulse per channel when sw_out[i] goes 1->0.
REQ-008 busy  output  1  SHALL be high while any channel is in COUNTING.

Function
REQ-009 Each bit of sw_in SHALL pass through a two-flop synchronizer; s[i] is the second flop output, and no other logic SHALL sample sw_in.
REQ-010 The four channels SHALL be fully independent, each with its own state register (STABLE/COUNTING) and its own counter.
REQ-011 The counter width SHALL be clog2(STABLE_CYCLES+1) bits, and the counter SHALL never wrap.
REQ-012 In STABLE with s[i]==sw_out[i], the channel SHALL hold: cnt=0, no pulse.
REQ-013 In STABLE with s[i]!=sw_out[i], the next state SHALL be COUNTING with cnt=1.
REQ-014 In COUNTING with s[i]==sw_out[i], the channel SHALL return to STABLE with cnt=0 and no output change (glitch rejected).
REQ-015 In COUNTING with s[i]!=sw_out[i] and cnt<STABLE_CYCLES-1, cnt SHALL increment.
REQ-016 In COUNTING with s[i]!=sw_out[i] and cnt==STABLE_CYCLES-1, at the next edge sw_out[i]<=s[i], the matching sw_rise[i] or sw_fall[i] SHALL go high, state SHALL return to STABLE, and cnt SHALL reset to 0.
REQ-017 sw_rise and sw_fall SHALL be registered, high for exactly one cycle per accepted transition, and never both high on the same bit.
REQ-018 Acceptance rule: a level change SHALL be accepted iff s[i] differs from sw_out[i] for at least STABLE_CYCLES consecutive sampling edges.
REQ-019 Latency: for a raw change held steady, with edge 0 defined as the edge where the first synchronizer flop captures it, sw_out[i] SHALL update at edge STABLE_CYCLES+1.
REQ-020 Simultaneous events: several channels SHALL be able to accept transitions, and pulse, in the same cycle with no arbitration.
REQ-021 busy SHALL be the registered OR of the four COUNTING states, with no combinational path from sw_in.
REQ-022 All outputs SHALL be driven directly from flops.

Reset
REQ-023 While rst=1 at a clock edge, all of the following SHALL clear: synchronizer flops=0, sw_out=4'b0000, sw_rise=sw_fall=4'b0000, all counters=0, all states=STABLE, busy=0.
REQ-024 A reset mid-count SHALL abort the count with no pulse.
REQ-025 rst SHALL take priority over every other update.
REQ-026 After rst deasserts with sw_in held high, each such channel SHALL rise through the normal latency and emit an sw_rise pulse.
REQ-027 There SHALL be no asynchronous reset path.

Verification (STABLE_CYCLES=4 unless noted)
REQ-028 Clean edge: sw_in[0] goes 0->1 before edge 0 and is held -> sw_out[0]=1 from edge 5; sw_rise[0]=1 for the single cycle after edge 5; busy high from edge 2 through edge 5.
REQ-029 Glitch boundary: sw_in[2] high for 3 cycles -> sw_out, sw_rise and sw_fall stay 0; sw_in[2] high for 4 cycles -> sw_out[2] rises, one sw_rise[2] pulse, then after the drop a fall is accepted with one sw_fall[2] pulse.
REQ-030 Bounce: sw_in[1] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> exactly one sw_rise[1] pulse, 5 edges after the final 0->1 capture.
REQ-031 Simultaneous: sw_in goes 4'b0000->4'b1111 in one cycle -> sw_out=4'b1111 and sw_rise=4'b1111 on the same cycle; the downstream NOR input sees all-ones after one update.
REQ-032 Reset mid-count: rst=1 for one cycle while channel 3 has cnt=2 -> after reset all outputs=0, with no pulse during or immediately after reset; with sw_in[3] still high, the rise completes 5 edges after rst drops.
REQ-033 Long hold: with STABLE_CYCLES=2^20 and the input held steady, cnt SHALL reach STABLE_CYCLES-1 without overflow and the transition SHALL be accepted at edge 2^20+1.
